// File: rtl/fprint_master_pkg.sv
// rtl/fprint_master_pkg.sv - command entry, FSM states and write-beat formatting helpers
`include "crc_defines.v"

package fprint_master_pkg;

  localparam int ADDR_W = `COMPARATOR_ADDRESS_WIDTH;
  localparam int DATA_W = `NIOS_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTL_WR,
    ST_LO_WR,
    ST_HI_WR
  } state_t;

  typedef struct packed {
    logic        is_ctl;
    logic        enable;
    logic [3:0]  task_id;
    logic [31:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Control writes hit slot 0 of the core's window, fingerprints the CRC slot.
  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [3:0] core_id, input logic is_ctl);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'({core_id, 4'h0});
    return is_ctl ? base : base + ADDR_W'(`COMPARATOR_CRC_OFFSET);
  endfunction

  function automatic logic [DATA_W-1:0] first_data(input cmd_t c);
    if (c.is_ctl) return DATA_W'({c.enable, c.task_id});
    return DATA_W'({c.data[15:0], 12'h000, c.task_id});
  endfunction

  function automatic logic [DATA_W-1:0] hi_data(input cmd_t c);
    return DATA_W'({c.data[31:16], `COMPARATOR_HI_MARKER, c.task_id});
  endfunction

  function automatic state_t first_state(input cmd_t c);
    return c.is_ctl ? ST_CTL_WR : ST_LO_WR;
  endfunction

endpackage

// File: rtl/crc_defines.v
// rtl/crc_defines.v - comparator address map, bus widths and fingerprint half markers
`ifndef CRC_DEFINES_V
`define CRC_DEFINES_V
`define COMPARATOR_ADDRESS_WIDTH 8
`define NIOS_DATA_WIDTH 32
`define COMPARATOR_CRC_OFFSET 4
`define COMPARATOR_HI_MARKER 12'h002
`endif

// File: rtl/fprint_cmd_fifo.sv
// rtl/fprint_cmd_fifo.sv - in-order command FIFO with head and second-entry lookahead
module fprint_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         peek,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign peek  = mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fprint_master.sv
// rtl/fprint_master.sv - buffers fingerprint and task-control commands, replays them as
// Avalon-MM writes to the comparator (fingerprints split into LO then HI beats)
`include "crc_defines.v"

module fprint_master
  import fprint_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [3:0]                           core_id,
  input  logic                                 fp_valid,
  input  logic [31:0]                          fp_data,
  input  logic [3:0]                           fp_task,
  output logic                                 fp_ready,
  input  logic                                 ctl_valid,
  input  logic                                 ctl_enable,
  input  logic [3:0]                           ctl_task,
  output logic                                 ctl_ready,
  output logic [`COMPARATOR_ADDRESS_WIDTH-1:0] m_address,
  output logic                                 m_write,
  output logic [`NIOS_DATA_WIDTH-1:0]          m_writedata,
  input  logic                                 m_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_d;
  logic              write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  cmd_t push_cmd, head, peek, next_cmd;
  logic push, pop, full, empty, done, more, have_next;

  assign ctl_ready = !full;
  assign fp_ready  = !full && !ctl_valid;
  assign push      = !full && (ctl_valid || fp_valid);

  always_comb begin
    push_cmd = '0;
    if (ctl_valid) begin
      push_cmd.is_ctl  = 1'b1;
      push_cmd.enable  = ctl_enable;
      push_cmd.task_id = ctl_task;
    end else begin
      push_cmd.task_id = fp_task;
      push_cmd.data    = fp_data;
    end
  end

  fprint_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .peek      (peek),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign busy = !empty || m_write;
  assign done = m_write && !m_waitrequest;

  // After popping the head, the next command is the second entry, or the one being pushed
  // this very cycle when the head was the only entry.
  assign more      = |fifo_count[CNT_W-1:1];
  assign have_next = more || push;
  assign next_cmd  = more ? peek : push_cmd;

  always_comb begin
    state_d = state;
    write_d = m_write;
    addr_d  = m_address;
    data_d  = m_writedata;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_d = first_state(head);
          write_d = 1'b1;
          addr_d  = cmd_addr(core_id, head.is_ctl);
          data_d  = first_data(head);
        end
      end
      ST_LO_WR: begin
        if (done) begin
          state_d = ST_HI_WR;
          data_d  = hi_data(head);
        end
      end
      ST_CTL_WR, ST_HI_WR: begin
        if (done) begin
          pop = 1'b1;
          if (have_next) begin
            state_d = first_state(next_cmd);
            addr_d  = cmd_addr(core_id, next_cmd.is_ctl);
            data_d  = first_data(next_cmd);
          end else begin
            state_d = ST_IDLE;
            write_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else begin
      state       <= state_d;
      m_write     <= write_d;
      m_address   <= addr_d;
      m_writedata <= data_d;
    end
  end

endmodule

// File: tb/tb_fprint_master.sv
// tb/tb_fprint_master.sv - scoreboard bench for fprint_master write ordering, stalls and reset
module tb_fprint_master;

  localparam int CRC_OFFSET = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_id;
  logic        fp_valid;
  logic [31:0] fp_data;
  logic [3:0]  fp_task;
  logic        fp_ready;
  logic        ctl_valid;
  logic        ctl_enable;
  logic [3:0]  ctl_task;
  logic        ctl_ready;
  logic [7:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [2:0]  fifo_count;
  logic        busy;

  fprint_master #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .core_id       (core_id),
    .fp_valid      (fp_valid),
    .fp_data       (fp_data),
    .fp_task       (fp_task),
    .fp_ready      (fp_ready),
    .ctl_valid     (ctl_valid),
    .ctl_enable    (ctl_enable),
    .ctl_task      (ctl_task),
    .ctl_ready     (ctl_ready),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .fifo_count    (fifo_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  prev_done = -10;
  int  last_done = -10;
  bit  rand_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && m_write && !m_waitrequest) begin
      if (sb.size() == 0) begin
        check("write_with_empty_scoreboard", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(m_address), 64'(mon_e.a));
        check("wr_data", 64'(m_writedata), 64'(mon_e.d));
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  task automatic exp_fp(input logic [31:0] d, input logic [3:0] t);
    wr_t e;
    e.a = 8'(core_id * 16 + CRC_OFFSET);
    e.d = {d[15:0], 12'h000, t};
    sb.push_back(e);
    e.d = {d[31:16], 12'h002, t};
    sb.push_back(e);
  endtask

  task automatic exp_ctl(input logic en, input logic [3:0] t);
    wr_t e;
    e.a = 8'(core_id * 16);
    e.d = {27'b0, en, t};
    sb.push_back(e);
  endtask

  task automatic send_fp(input logic [31:0] d, input logic [3:0] t);
    int n = 0;
    fp_valid = 1'b1;
    fp_data  = d;
    fp_task  = t;
    @(negedge clk);
    while (!fp_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("fp_accept_timeout", 64'(n < 300), 64'd1);
    if (n < 300) exp_fp(d, t);
    @(posedge clk);
    #1 fp_valid = 1'b0;
  endtask

  task automatic send_ctl(input logic en, input logic [3:0] t);
    int n = 0;
    ctl_valid  = 1'b1;
    ctl_enable = en;
    ctl_task   = t;
    @(negedge clk);
    while (!ctl_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ctl_accept_timeout", 64'(n < 300), 64'd1);
    if (n < 300) exp_ctl(en, t);
    @(posedge clk);
    #1 ctl_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 500), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_write();
    int n = 0;
    @(negedge clk);
    while (!m_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("write_start_timeout", 64'(n < 50), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    core_id = 4'd1;
    fp_valid = 1'b0;
    fp_data = '0;
    fp_task = '0;
    ctl_valid = 1'b0;
    ctl_enable = 1'b0;
    ctl_task = '0;
    m_waitrequest = 1'b0;
    #3;
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_m_address", 64'(m_address), 64'd0);
    check("rst_m_writedata", 64'(m_writedata), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fp_ready", 64'(fp_ready), 64'd1);
    check("rst_ctl_ready", 64'(ctl_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // single fingerprint, no stall: LO then HI on consecutive cycles
    send_fp(32'hDEADBEEF, 4'd0);
    check("t1_no_write_yet", 64'(m_write), 64'd0);
    check("t1_count_one", 64'(fifo_count), 64'd1);
    @(posedge clk);
    #1;
    check("t1_write_rises", 64'(m_write), 64'd1);
    check("t1_lo_addr", 64'(m_address), 64'd20);
    check("t1_lo_data", 64'(m_writedata), 64'h0000_0000_BEEF_0000);
    wait_idle();
    check("t1_back_to_back", 64'(last_done - prev_done), 64'd1);

    // control then fingerprint keeps order
    send_ctl(1'b1, 4'd3);
    send_fp(32'h12345678, 4'd3);
    wait_idle();

    // LO held while stalled
    m_waitrequest = 1'b1;
    send_fp(32'hCAFEF00D, 4'd7);
    wait_write();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_write", 64'(m_write), 64'd1);
      check("t3_hold_addr", 64'(m_address), 64'd20);
      check("t3_hold_data", 64'(m_writedata), 64'h0000_0000_F00D_0007);
    end
    @(posedge clk);
    #1 m_waitrequest = 1'b0;
    wait_idle();
    check("t3_hi_after_release", 64'(last_done - prev_done), 64'd1);

    // fill the FIFO under stall, fifth waits for room
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) send_fp(32'h1111_1111 * (i + 1), 4'(i + 8));
    check("t4_fp_ready_full", 64'(fp_ready), 64'd0);
    check("t4_ctl_ready_full", 64'(ctl_ready), 64'd0);
    check("t4_count_full", 64'(fifo_count), 64'd4);
    m_waitrequest = 1'b0;
    send_fp(32'h5555AAAA, 4'd5);
    wait_idle();

    // simultaneous offer: control wins, fingerprint next cycle
    ctl_valid = 1'b1;
    ctl_enable = 1'b0;
    ctl_task = 4'd2;
    fp_valid = 1'b1;
    fp_data = 32'hA5A55A5A;
    fp_task = 4'd9;
    @(negedge clk);
    check("t5_ctl_ready", 64'(ctl_ready), 64'd1);
    check("t5_fp_blocked", 64'(fp_ready), 64'd0);
    exp_ctl(1'b0, 4'd2);
    @(posedge clk);
    #1 ctl_valid = 1'b0;
    @(negedge clk);
    check("t5_fp_ready_next", 64'(fp_ready), 64'd1);
    exp_fp(32'hA5A55A5A, 4'd9);
    @(posedge clk);
    #1 fp_valid = 1'b0;
    wait_idle();

    // reset between LO and HI discards the half-written fingerprint
    m_waitrequest = 1'b1;
    send_fp(32'h0BADF00D, 4'hC);
    wait_write();
    @(posedge clk);
    #1 m_waitrequest = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 m_waitrequest = 1'b1;
    @(negedge clk);
    check("t6_hi_pending", 64'(m_writedata), 64'h0000_0000_0BAD_002C);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_m_write", 64'(m_write), 64'd0);
    check("t6_rst_count", 64'(fifo_count), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_addr", 64'(m_address), 64'd0);
    sb.delete();
    core_id = 4'd5;
    @(posedge clk);
    #1;
    m_waitrequest = 1'b0;
    reset = 1'b0;
    send_fp(32'h600DCAFE, 4'd1);
    wait_idle();

    // random mix under random stalls
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_waitrequest = ($urandom_range(0, 2) == 0);
        end
        m_waitrequest = 1'b0;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          if ($urandom_range(0, 3) == 0) send_ctl(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
          else send_fp($urandom, 4'($urandom_range(0, 15)));
        end
        rand_done = 1'b1;
      end
    join
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
